// File: rtl/proc_pkg.sv
// ---------------------------------------------------------------------------
// proc_pkg
//  Shared definitions for the memory-access/writeback stage: opcode encodings
//  for the two memory op classes, the stage FSM state type and datapath widths.
//  Optional feature macro used by the stage: MEM_WB_FWD_EN (forwarding outputs).
// ---------------------------------------------------------------------------
package proc_pkg;

  localparam logic [3:0] OP_LOAD  = 4'hE;
  localparam logic [3:0] OP_STORE = 4'hF;

  localparam int DATA_W  = 8;
  localparam int RADDR_W = 3;
  localparam int MADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    LD_WB   = 2'd2
  } mwb_state_t;

endpackage

// File: rtl/mem_rd_timer.sv
// ---------------------------------------------------------------------------
// mem_rd_timer
//  Loadable down-counter that times the data-memory read latency. Loading
//  puts DM_RD_LATENCY into the counter; it then counts down one per cycle
//  and sits at zero. o_done is high whenever the count is zero.
// Ports
//  clk     in  clock, rising edge
//  rst_n   in  asynchronous active-low reset
//  i_load  in  load the counter with DM_RD_LATENCY
//  o_done  out count has reached zero
// ---------------------------------------------------------------------------
module mem_rd_timer #(
  parameter int DM_RD_LATENCY = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_done
);

  localparam int CW = $clog2(DM_RD_LATENCY + 1);

  logic [CW-1:0] r_count;

  // Down-counter: load on request, otherwise decrement and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CW'(DM_RD_LATENCY);
    end else if (r_count != '0) begin
      r_count <= r_count - CW'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//  Memory-access/writeback stage downstream of the execution unit. Each
//  accepted op produces exactly one of: a data-memory store strobe, a
//  multi-cycle load followed by a register writeback, or an ALU writeback.
//  Loads stall upstream (in_ready low) until their writeback cycle.
//  Optional feature macro: MEM_WB_FWD_EN -- when defined, fwd_valid/fwd_reg/
//  fwd_data expose the pending or committing register write; otherwise they
//  are tied to zero.
// Ports
//  clk, reset (async active-low)
//  in_valid/in_ready handshake; opcode, result, write_enable, store_data,
//   mem_addr, dest_reg sampled on accept
//  dm_addr, dm_wdata, dm_we, dm_re out; dm_rdata in  (data memory)
//  rf_we, rf_waddr, rf_wdata                         (register file)
//  retire_count                                      (retired-op counter)
//  fwd_valid, fwd_reg, fwd_data                      (forwarding)
// ---------------------------------------------------------------------------
module mem_wb_stage
  import proc_pkg::*;
#(
  parameter int DM_RD_LATENCY = 2,
  parameter int CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           opcode,
  input  logic [DATA_W-1:0]    result,
  input  logic                 write_enable,
  input  logic [DATA_W-1:0]    store_data,
  input  logic [MADDR_W-1:0]   mem_addr,
  input  logic [RADDR_W-1:0]   dest_reg,
  output logic [MADDR_W-1:0]   dm_addr,
  output logic [DATA_W-1:0]    dm_wdata,
  output logic                 dm_we,
  output logic                 dm_re,
  input  logic [DATA_W-1:0]    dm_rdata,
  output logic                 rf_we,
  output logic [RADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic [CNT_W-1:0]     retire_count,
  output logic                 fwd_valid,
  output logic [RADDR_W-1:0]   fwd_reg,
  output logic [DATA_W-1:0]    fwd_data
);

  mwb_state_t           r_state;
  logic [RADDR_W-1:0]   r_dest;
  logic [MADDR_W-1:0]   r_dm_addr;
  logic [DATA_W-1:0]    r_dm_wdata;
  logic                 r_dm_we;
  logic                 r_dm_re;
  logic                 r_rf_we;
  logic [RADDR_W-1:0]   r_rf_waddr;
  logic [DATA_W-1:0]    r_rf_wdata;
  logic [CNT_W-1:0]     r_retire_count;

  logic                 w_accept;
  logic                 w_is_load;
  logic                 w_is_store;
  logic                 w_timer_done;
  logic [1:0]           w_retire_inc;

  // in_ready is forced low while reset is asserted even though the state is IDLE.
  assign in_ready   = reset & ((r_state == IDLE) | (r_state == LD_WB));
  assign w_accept   = in_valid & in_ready;
  assign w_is_load  = (opcode == OP_LOAD);
  assign w_is_store = (opcode == OP_STORE);

  // An LD_WB cycle retires the load; an ALU/STORE accepted in that same
  // cycle retires too, so up to two retirements can land in one cycle.
  assign w_retire_inc = {1'b0, (r_state == LD_WB)} +
                        {1'b0, (w_accept & ~w_is_load)};

  mem_rd_timer #(
    .DM_RD_LATENCY (DM_RD_LATENCY)
  ) u_rd_timer (
    .clk    (clk),
    .rst_n  (reset),
    .i_load (w_accept & w_is_load),
    .o_done (w_timer_done)
  );

  // Stage FSM with registered memory/register-file strobes and retire counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_dest         <= '0;
      r_dm_addr      <= '0;
      r_dm_wdata     <= '0;
      r_dm_we        <= 1'b0;
      r_dm_re        <= 1'b0;
      r_rf_we        <= 1'b0;
      r_rf_waddr     <= '0;
      r_rf_wdata     <= '0;
      r_retire_count <= '0;
    end else begin
      // Strobes are single-cycle pulses unless re-asserted below.
      r_dm_we        <= 1'b0;
      r_dm_re        <= 1'b0;
      r_rf_we        <= 1'b0;
      r_retire_count <= r_retire_count + CNT_W'(w_retire_inc);
      case (r_state)
        IDLE, LD_WB: begin
          r_state <= IDLE;
          if (w_accept) begin
            if (w_is_load) begin
              r_dm_re   <= 1'b1;
              r_dm_addr <= mem_addr;
              r_dest    <= dest_reg;
              r_state   <= RD_WAIT;
            end else if (w_is_store) begin
              r_dm_we    <= 1'b1;
              r_dm_addr  <= mem_addr;
              r_dm_wdata <= store_data;
            end else begin
              r_rf_we <= write_enable;
              if (write_enable) begin
                r_rf_waddr <= dest_reg;
                r_rf_wdata <= result;
              end else begin
                r_rf_waddr <= r_rf_waddr;
              end
            end
          end else begin
            r_state <= IDLE;
          end
        end
        RD_WAIT: begin
          // Read data is valid in the cycle the timer hits zero.
          if (w_timer_done) begin
            r_state    <= LD_WB;
            r_rf_we    <= 1'b1;
            r_rf_waddr <= r_dest;
            r_rf_wdata <= dm_rdata;
          end else begin
            r_state <= RD_WAIT;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign dm_addr      = r_dm_addr;
  assign dm_wdata     = r_dm_wdata;
  assign dm_we        = r_dm_we;
  assign dm_re        = r_dm_re;
  assign rf_we        = r_rf_we;
  assign rf_waddr     = r_rf_waddr;
  assign rf_wdata     = r_rf_wdata;
  assign retire_count = r_retire_count;

`ifdef MEM_WB_FWD_EN
  // During RD_WAIT only the destination is meaningful; the decoder stalls on it.
  assign fwd_valid = (r_state == RD_WAIT) | (r_state == LD_WB) | r_rf_we;
  assign fwd_reg   = r_rf_we ? r_rf_waddr : r_dest;
  assign fwd_data  = r_rf_we ? r_rf_wdata : {DATA_W{1'b0}};
`else
  assign fwd_valid = 1'b0;
  assign fwd_reg   = {RADDR_W{1'b0}};
  assign fwd_data  = {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
//  Directed bench for mem_wb_stage (CNT_W=4 so the retire counter wraps
//  quickly, DM_RD_LATENCY=2). Table-driven ALU/STORE vectors followed by
//  hand-written load, reset-during-load and counter-wrap sequences.
//  Honours MEM_WB_FWD_EN for the forwarding outputs.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;
  import proc_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] opcode;
  logic [7:0] result;
  logic       write_enable;
  logic [7:0] store_data;
  logic [3:0] mem_addr;
  logic [2:0] dest_reg;
  logic [3:0] dm_addr;
  logic [7:0] dm_wdata;
  logic       dm_we;
  logic       dm_re;
  logic [7:0] dm_rdata;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [3:0] retire_count;
  logic       fwd_valid;
  logic [2:0] fwd_reg;
  logic [7:0] fwd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DM_RD_LATENCY(2), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .result(result), .write_enable(write_enable),
    .store_data(store_data), .mem_addr(mem_addr), .dest_reg(dest_reg),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_re(dm_re),
    .dm_rdata(dm_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .retire_count(retire_count),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
  );

  // Data-memory model: read data appears two cycles after the dm_re cycle.
  logic [7:0] mem [16];
  logic [7:0] rd_p1 = 8'hEE;
  logic [7:0] rd_p2 = 8'hEE;
  always @(posedge clk) begin
    rd_p1 <= dm_re ? mem[dm_addr] : 8'hEE;
    rd_p2 <= rd_p1;
  end
  assign dm_rdata = rd_p2;

  typedef struct {
    logic [3:0] op;
    logic [7:0] res;
    logic       we;
    logic [7:0] sd;
    logic [3:0] ma;
    logic [2:0] dr;
    logic       e_rf_we;
    logic [2:0] e_rf_waddr;
    logic [7:0] e_rf_wdata;
    logic       e_dm_we;
    logic [3:0] e_dm_addr;
    logic [7:0] e_dm_wdata;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [7:0] res, input logic we,
                       input logic [7:0] sd, input logic [3:0] ma, input logic [2:0] dr);
    in_valid     = 1'b1;
    opcode       = op;
    result       = res;
    write_enable = we;
    store_data   = sd;
    mem_addr     = ma;
    dest_reg     = dr;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h80 | 8'(i);
    mem[4] = 8'h77;
    mem[9] = 8'h2B;

    //                op     res    we    sd     ma    dr   rfwe  wa    wd     dmwe  da     dd     cnt
    vecs[0] = '{4'h2, 8'h5A, 1'b1, 8'h00, 4'h0, 3'd3, 1'b1, 3'd3, 8'h5A, 1'b0, 4'h0, 8'h00, 4'd1};
    vecs[1] = '{4'h3, 8'hA5, 1'b1, 8'h00, 4'h0, 3'd1, 1'b1, 3'd1, 8'hA5, 1'b0, 4'h0, 8'h00, 4'd2};
    vecs[2] = '{4'h7, 8'h11, 1'b0, 8'h00, 4'h0, 3'd6, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 8'h00, 4'd3};
    vecs[3] = '{4'hF, 8'h00, 1'b1, 8'hC3, 4'hA, 3'd2, 1'b0, 3'd0, 8'h00, 1'b1, 4'hA, 8'hC3, 4'd4};
    vecs[4] = '{4'h0, 8'hFF, 1'b1, 8'h00, 4'h0, 3'd7, 1'b1, 3'd7, 8'hFF, 1'b0, 4'h0, 8'h00, 4'd5};
    vecs[5] = '{4'hF, 8'h00, 1'b0, 8'h3C, 4'h5, 3'd0, 1'b0, 3'd0, 8'h00, 1'b1, 4'h5, 8'h3C, 4'd6};

    reset = 1'b0;
    drive(4'h0, 8'h00, 1'b0, 8'h00, 4'h0, 3'd0);
    in_valid = 1'b0;
    step();
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_strobes", {dm_we, dm_re, rf_we}, 0);

    reset = 1'b1;
    repeat (5) step();
    chk("idle_strobes", {dm_we, dm_re, rf_we}, 0);
    chk("idle_count", retire_count, 0);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_fwd_valid", fwd_valid, 0);

    // Back-to-back ALU/STORE vectors at full rate.
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].op, vecs[i].res, vecs[i].we, vecs[i].sd, vecs[i].ma, vecs[i].dr);
      step();
      chk($sformatf("v%0d_rf_we", i), rf_we, vecs[i].e_rf_we);
      chk($sformatf("v%0d_dm_we", i), dm_we, vecs[i].e_dm_we);
      chk($sformatf("v%0d_dm_re", i), dm_re, 0);
      chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      chk($sformatf("v%0d_count", i), retire_count, vecs[i].e_cnt);
      if (vecs[i].e_rf_we) begin
        chk($sformatf("v%0d_rf_waddr", i), rf_waddr, vecs[i].e_rf_waddr);
        chk($sformatf("v%0d_rf_wdata", i), rf_wdata, vecs[i].e_rf_wdata);
      end
      if (vecs[i].e_dm_we) begin
        chk($sformatf("v%0d_dm_addr", i), dm_addr, vecs[i].e_dm_addr);
        chk($sformatf("v%0d_dm_wdata", i), dm_wdata, vecs[i].e_dm_wdata);
      end
`ifdef MEM_WB_FWD_EN
      chk($sformatf("v%0d_fwd_valid", i), fwd_valid, vecs[i].e_rf_we);
      if (vecs[i].e_rf_we) begin
        chk($sformatf("v%0d_fwd_reg", i), fwd_reg, vecs[i].e_rf_waddr);
        chk($sformatf("v%0d_fwd_data", i), fwd_data, vecs[i].e_rf_wdata);
      end
`else
      chk($sformatf("v%0d_fwd_tied", i), {fwd_valid, fwd_reg, fwd_data}, 0);
`endif
    end
    in_valid = 1'b0;
    step();
    chk("post_table_strobes", {dm_we, dm_re, rf_we}, 0);
    chk("post_table_count", retire_count, 6);

    // LOAD addr 4 -> reg 5, then a second LOAD held valid through the stall.
    drive(OP_LOAD, 8'h00, 1'b0, 8'h00, 4'h4, 3'd5);
    step();                                            // T+1
    chk("ld_dm_re", dm_re, 1);
    chk("ld_dm_addr", dm_addr, 4'h4);
    chk("ld_t1_in_ready", in_ready, 0);
    chk("ld_t1_rf_we", rf_we, 0);
    drive(OP_LOAD, 8'h00, 1'b0, 8'h00, 4'h9, 3'd2);    // held while stalled
    step();                                            // T+2
    chk("ld_t2_in_ready", in_ready, 0);
    chk("ld_t2_strobes", {dm_we, dm_re, rf_we}, 0);
`ifdef MEM_WB_FWD_EN
    chk("ld_t2_fwd_valid", fwd_valid, 1);
    chk("ld_t2_fwd_reg", fwd_reg, 5);
`endif
    step();                                            // T+3
    chk("ld_t3_in_ready", in_ready, 0);
    chk("ld_t3_strobes", {dm_we, dm_re, rf_we}, 0);
`ifdef MEM_WB_FWD_EN
    chk("ld_t3_fwd_valid", fwd_valid, 1);
    chk("ld_t3_fwd_reg", fwd_reg, 5);
`endif
    step();                                            // T+4: LD_WB
    chk("ld_t4_rf_we", rf_we, 1);
    chk("ld_t4_rf_waddr", rf_waddr, 5);
    chk("ld_t4_rf_wdata", rf_wdata, 8'h77);
    chk("ld_t4_in_ready", in_ready, 1);
    chk("ld_t4_dm", {dm_we, dm_re}, 0);
`ifdef MEM_WB_FWD_EN
    chk("ld_t4_fwd", {fwd_valid, fwd_reg, fwd_data}, {1'b1, 3'd5, 8'h77});
`endif
    step();                                            // second load accepted in LD_WB
    in_valid = 1'b0;
    chk("ld2_dm_re", dm_re, 1);
    chk("ld2_dm_addr", dm_addr, 4'h9);
    chk("ld2_rf_we", rf_we, 0);
    chk("ld2_in_ready", in_ready, 0);
    step();
    step();
    step();
    chk("ld2_rf_we_wb", rf_we, 1);
    chk("ld2_rf_waddr", rf_waddr, 2);
    chk("ld2_rf_wdata", rf_wdata, 8'h2B);
    step();
    chk("ld_count", retire_count, 8);
    chk("ld_idle_strobes", {dm_we, dm_re, rf_we}, 0);

    // Reset pulsed at T+2 of a load: writeback must never appear.
    drive(OP_LOAD, 8'h00, 1'b0, 8'h00, 4'h4, 3'd5);
    step();                                            // T+1
    in_valid = 1'b0;
    step();                                            // T+2
    reset = 1'b0;
    #2;
    chk("rstld_in_ready", in_ready, 0);
    chk("rstld_strobes", {dm_we, dm_re, rf_we}, 0);
    chk("rstld_count_async", retire_count, 0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("rstld_rf_we_%0d", i), rf_we, 0);
    end
    chk("rstld_in_ready_after", in_ready, 1);
    chk("rstld_count", retire_count, 0);

    // Retire counter wrap at CNT_W=4: 15 ops -> all ones, one more -> 0.
    drive(4'h1, 8'h00, 1'b0, 8'h00, 4'h0, 3'd0);
    repeat (15) step();
    chk("wrap_all_ones", retire_count, 4'hF);
    chk("wrap_no_rf_we", rf_we, 0);
    step();
    chk("wrap_zero", retire_count, 0);
    in_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
